// File: rtl/mostrar_producto.sv
// mostrar_producto: signed 16-bit product to sign + 5 BCD digits on a multiplexed 8-digit 7-segment display.
// Optional build macro LZ_BLANK_EN: blank leading zeros and float the minus sign next to the leading digit.
module mostrar_producto #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic [15:0]           producto,
    input  logic                  producto_valido,
    output logic                  ocupado,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state, state_n;
    logic [15:0]     mag;
    logic [15:0]     abs_in;
    logic [19:0]     bcd;
    logic [19:0]     bcd_adj;
    logic [4:0]      step;
    logic            sign;
    logic [19:0]     disp_bcd;
    logic            disp_neg;
    logic [CW-1:0]   cnt;
    logic            wrap;
    logic [IW-1:0]   idx, idx_n;
    logic [6:0]      codes [NUM_DIGITS];
`ifdef LZ_BLANK_EN
    logic [2:0]      msd;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        for (int i = 0; i < 5; i++)
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        return r;
    endfunction

    // |-32768| = 32768 still fits in 16 unsigned bits, so the magnitude needs no 17th bit in the shifter
    assign abs_in  = producto[15] ? ~producto + 16'd1 : producto;
    assign bcd_adj = dd_adjust(bcd);
    assign ocupado = (state != IDLE);
    assign DP      = 1'b1;
    assign wrap    = (cnt == CW'(SCAN_DIV - 1));
    assign idx_n   = wrap ? ((idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1) : idx;

    // conversion state register
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // conversion next-state: capture, 16 shift steps, one commit
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = producto_valido ? SHIFT : IDLE;
            SHIFT:   state_n = (step == 5'd15) ? COMMIT : SHIFT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // double-dabble datapath and display registers, which only change at commit
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            mag      <= '0;
            bcd      <= '0;
            step     <= '0;
            sign     <= 1'b0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (producto_valido) begin
                    sign <= producto[15];
                    mag  <= abs_in;
                    bcd  <= '0;
                    step <= '0;
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[18:0], mag[15]};
                    mag  <= {mag[14:0], 1'b0};
                    step <= step + 5'd1;
                end
                COMMIT: begin
                    disp_bcd <= bcd;
                    disp_neg <= sign && (bcd != '0);
                end
                default: ;
            endcase
        end
    end

    // segment pattern for every digit position from the committed value
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) codes[i] = BLANK;
        for (int i = 0; i < 5; i++) codes[i] = seg7(disp_bcd[i*4 +: 4]);
`ifdef LZ_BLANK_EN
        msd = 3'd0;
        for (int i = 1; i < 5; i++) if (disp_bcd[i*4 +: 4] != 4'd0) msd = 3'(i);
        for (int i = 1; i < 6; i++)
            if (i > int'(msd)) codes[i] = (disp_neg && i == int'(msd) + 1) ? MINUS : BLANK;
`else
        codes[5] = disp_neg ? MINUS : BLANK;
`endif
    end

    // free-running digit scan; AN and SEG are registered together so they switch on the same edge
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
            AN  <= '1;
            SEG <= BLANK;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            idx <= idx_n;
            AN  <= ~(NUM_DIGITS'(1) << idx_n);
            SEG <= codes[idx_n];
        end
    end
endmodule

// File: tb/tb_mostrar_producto.sv
// tb_mostrar_producto: random strobes against a decimal-arithmetic display model, plus literal digit checks.
module tb_mostrar_producto;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] prod = '0;
    logic        ocupado, DP;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;

    localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    mostrar_producto #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
        .CLK100MHZ(clk), .reset(reset), .producto(prod), .producto_valido(valid),
        .ocupado(ocupado), .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 clk = ~clk;

    // expected pattern of digit d when the display holds decimal value v
    function automatic logic [6:0] model_seg(input int v, input int d);
        int m, nd, p;
        bit neg;
        logic [3:0] q;
        neg = v < 0;
        m = neg ? -v : v;
        nd = 1;
        p = 10;
        while (nd < 5 && m >= p) begin nd++; p *= 10; end
        p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        q = 4'((m / p) % 10);
`ifdef LZ_BLANK_EN
        if (d < nd) return DIG[q];
        if (d == nd && neg) return 7'h3F;
`else
        if (d < 5) return DIG[q];
        if (d == 5 && neg) return 7'h3F;
`endif
        return 7'h7F;
    endfunction

    int          k = 0, cnt = 0, disp = 0, pend = 0;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_seg = 7'h7F;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k = 0; cnt = 0; disp = 0; m_an = 8'hFF; m_seg = 7'h7F;
        end else begin
            k++;
            m_an  = ~(8'b1 << ((k / 4) % 8));
            m_seg = model_seg(disp, (k / 4) % 8);
            if (cnt == 0) begin
                if (valid) begin pend = int'($signed(prod)); cnt = 17; end
            end else begin
                cnt--;
                if (cnt == 0) disp = pend;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (started) begin
            checks += 4;
            if (ocupado !== (cnt > 0)) begin errors++; $display("FAIL ocupado @%0t: got %b want %b", $time, ocupado, cnt > 0); end
            if (AN !== m_an) begin errors++; $display("FAIL AN @%0t: got %h want %h", $time, AN, m_an); end
            if (SEG !== m_seg) begin errors++; $display("FAIL SEG @%0t: got %b want %b (AN %h)", $time, SEG, m_seg, AN); end
            if (DP !== 1'b1) begin errors++; $display("FAIL DP @%0t: got %b want 1", $time, DP); end
        end
    end

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        prod = v;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        prod = 16'($urandom);
    endtask

    task automatic busy_len(input int want, input string nm);
        int n = 0;
        while (ocupado === 1'b1 && n < 60) begin n++; @(negedge clk); end
        checks++;
        if (n != want) begin errors++; $display("FAIL %s: busy cycles got %0d want %0d", nm, n, want); end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ocupado !== 1'b0 && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL idle timeout: ocupado got %b want 0", ocupado); end
    endtask

    task automatic check_digit(input int d, input logic [6:0] e, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk);
            #3;
            ok = (AN === ~(8'b1 << d));
        end
        checks++;
        if (!ok || SEG !== e) begin
            errors++;
            $display("FAIL %s: digit %0d SEG got %b want %b (anode seen %0d)", nm, d, SEG, e, ok);
        end
    endtask

    logic [6:0] e2 [8] = '{7'h02, 7'h12, 7'h24, 7'h02, 7'h79, 7'h3F, 7'h7F, 7'h7F};
    logic [6:0] e3 [8] = '{7'h19, 7'h00, 7'h30, 7'h02, 7'h79, 7'h7F, 7'h7F, 7'h7F};
`ifdef LZ_BLANK_EN
    logic [6:0] e4 [8] = '{7'h79, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    logic [6:0] e4 [8] = '{7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F};
`endif
    logic [6:0] e6 [8] = '{7'h00, 7'h02, 7'h78, 7'h24, 7'h30, 7'h3F, 7'h7F, 7'h7F};

    initial begin
        started = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (AN !== 8'hFF || SEG !== 7'h7F) begin errors++; $display("FAIL reset outputs: AN %h SEG %b want ff 1111111", AN, SEG); end
        reset = 1'b1;
        check_digit(0, 7'h40, "t1 digit0");
        check_digit(7, 7'h7F, "t1 digit7");
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL t1 ocupado: got %b want 0", ocupado); end

        strobe(16'hC080);
        busy_len(17, "t2 busy");
        for (int d = 0; d < 8; d++) check_digit(d, e2[d], "t2 -16256");

        strobe(16'h4000);
        busy_len(17, "t3 busy");
        for (int d = 0; d < 8; d++) check_digit(d, e3[d], "t3 16384");

        strobe(16'hFFFF);
        busy_len(17, "t4 busy");
        for (int d = 0; d < 8; d++) check_digit(d, e4[d], "t4 -1");

        strobe(16'h0005);
        repeat (4) @(negedge clk);
        prod = 16'h0009;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        busy_len(12, "t5 ignored strobe");
        check_digit(0, 7'h12, "t5 digit0");

        strobe(16'h8000);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL t6 async abort: ocupado got %b want 0", ocupado); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_digit(0, 7'h40, "t6 zero digit0");
        check_digit(5, 7'h7F, "t6 zero digit5");
        strobe(16'h8000);
        busy_len(17, "t6 busy");
        for (int d = 0; d < 8; d++) check_digit(d, e6[d], "t6 -32768");

        for (int n = 0; n < 200; n++) begin
            int sel;
            logic [15:0] v;
            repeat ($urandom_range(0, 24)) @(negedge clk);
            sel = $urandom_range(0, 7);
            v = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : (sel == 2) ? 16'h7FFF :
                (sel == 3) ? 16'hFFFF : 16'($urandom);
            strobe(v);
        end
        wait_idle();
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
